prescaler_multi: RTL and testbench
==================================

Name: prescaler_multi

Overview:
Parametrised successor of the single fixed-ratio prescaler. It provides CHANNELS independent clock dividers driven from the 100 MHz board clock, and each channel has a runtime-loadable divisor. Every channel produces a registered square clock_out and a one-cycle tick strobe, with per-channel enable and a global phase-sync. It feeds the CPU step clock (1 Hz / 10 Hz selectable) and display/debounce timing.

Parameters:
CHANNELS, 2, number of independent divider channels (>=1)
WIDTH, 32, counter/divisor width in bits
DEFAULT_DIVISOR, 100_000_000, divisor loaded into every channel at reset (full output period in clock_in cycles; 1 Hz at 100 MHz)

Ports:
clock_in  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
enable  input  CHANNELS  per-channel run enable
sync  input  1  one-cycle pulse; restarts all channels at phase 0
load_valid  input  1  divisor write strobe
load_channel  input  max(1,$clog2(CHANNELS))  target channel of write
load_divisor  input  WIDTH  new divisor value
clock_out  output  CHANNELS  divided square clock, registered
tick  output  CHANNELS  one-cycle strobe per period, registered

Behaviour:
- Reset (sync, active-high): divisor[c]=DEFAULT_DIVISOR, count[c]=0, clock_out=0, tick=0 for all channels. Reset overrides load/sync/enable.
- Per channel, with divisor d, count ranges 0..d-1. On each enabled edge, update in this order:
  - wrap = (count == d-1)
  - count <= wrap ? 0 : count+1
  - tick <= wrap
  - clock_out <= (count_next < ceil(d/2)), where ceil(d/2) = (d+1)>>1 computed in WIDTH+1 bits
- Resulting timing:
  - Output period is exactly d cycles.
  - High time is ceil(d/2) and low time is floor(d/2). Odd d is high-biased.
  - tick is high in the cycle where count==0 following a wrap.
  - First period after reset: clock_out is low for 1 cycle before the pattern starts.
- Enable low: count, clock_out, divisor held; tick forced 0 the next cycle. Re-enable resumes from the held count with no extra cycle.
- d==0: channel halted; count held at 0, clock_out<=0, tick<=0 regardless of enable.
- d==1: wrap every cycle; tick=1 and clock_out=1 continuously while enabled.
- Load (load_valid=1):
  - divisor[load_channel] <= load_divisor.
  - That channel's count <= 0, clock_out <= 0, tick <= 0 on the same edge. The new ratio applies from the next edge.
  - Load applies even when the channel's enable is low; the channel then holds at phase 0.
  - load_channel >= CHANNELS: ignored, no state change.
- Sync: every channel gets count<=0, clock_out<=0, tick<=0 on that edge; divisors unchanged. Channels with enable high restart in phase-aligned lockstep.
- Load and sync on the same edge: both apply. Loaded channel gets the new divisor; all channels restart at 0.
- Reset mid-period: next edge restores reset state, and the divisor reverts to DEFAULT_DIVISOR.
- Counter arithmetic is WIDTH bits unsigned. count never exceeds d-1, so there is no overflow path.
- Latency: load, sync and enable all take effect on the edge they are sampled on. Outputs reflect them one cycle later.

Optional Feature:
PRESCALER_PHASE_OUT_EN
- Defined: adds output port phase, width CHANNELS*WIDTH, exposing each channel's live count register (channel c at bits [c*WIDTH +: WIDTH]). Used for debug LEDs and for bench phase checks.
- Undefined: port absent. No other behaviour change.

Decomposition:
- Package prescaler_pkg:
  - divisor_t (logic [WIDTH-1:0]), as a typedef driven by a package localparam default of 32.
  - Constant DIVISOR_1HZ = 100_000_000.
  - Constant DIVISOR_10HZ = 10_000_000.
- Sub-module prescaler_channel: one divider holding the count, divisor, clock_out and tick registers, with load/sync/enable inputs. prescaler_multi instantiates it CHANNELS times in a generate loop and decodes load_channel.

Test Plan:
- Reset then load ch0 d=4, enable=1: clock_out[0] repeats 1,1,0,0; tick[0] high once per 4 cycles, coincident with clock_out rising; period measured 4 over 20 periods.
- Load ch1 d=5: high 3, low 2 cycles. Load d=1: tick and clock_out constant 1. Load d=0: both stay 0 for 50 cycles.
- ch0 d=4, ch1 d=6, both enabled; pulse sync at arbitrary offset: both clock_out rise together 1 cycle later; phase (with PRESCALER_PHASE_OUT_EN) reads 1,1.
- ch0 d=8, drop enable[0] at count=3 for 10 cycles: outputs frozen, tick 0; re-enable: count resumes 4,5,6,7,0 and tick fires at the expected cycle.
- Same-edge load ch0 d=3 and sync with ch1 d=6: ch0 period 3, ch1 period 6, both phase 0 together. load_channel=CHANNELS: no change.
- Assert reset mid-period after loading d=10: next cycle all outputs 0 and divisor back to DEFAULT_DIVISOR (check via phase reaching >10 without tick).

Source files
------------

// File: rtl/prescaler_pkg.sv
// Shared types and standard divisor constants for the multi-channel prescaler.
package prescaler_pkg;

   localparam int unsigned DIVISOR_WIDTH = 32;

   typedef logic [DIVISOR_WIDTH-1:0] divisor_t;

   // Full-period divisors for the 100 MHz board clock
   localparam divisor_t DIVISOR_1HZ  = 100_000_000;
   localparam divisor_t DIVISOR_10HZ = 10_000_000;

endpackage

// File: rtl/prescaler_channel.sv
// One runtime-loadable clock divider: count, divisor, square clock_out and tick.
// Optional `phase` debug port under PRESCALER_PHASE_OUT_EN.
module prescaler_channel
   import prescaler_pkg::*;
#(
   parameter int unsigned          WIDTH           = DIVISOR_WIDTH,
   parameter logic [WIDTH-1:0]     DEFAULT_DIVISOR = WIDTH'(DIVISOR_1HZ)
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             sync,
   input  logic             load,
   input  logic [WIDTH-1:0] load_divisor,
   output logic             clock_out,
   output logic             tick
`ifdef PRESCALER_PHASE_OUT_EN
   ,
   output logic [WIDTH-1:0] phase
`endif
);

   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH:0]   half;
   logic             wrap;
   logic             high_next;

   // ceil(d/2) is formed one bit wider so d = all-ones cannot overflow
   always_comb begin
      wrap       = (count == (divisor - WIDTH'(1)));
      count_next = wrap ? '0 : count + WIDTH'(1);
      half       = ({1'b0, divisor} + (WIDTH+1)'(1)) >> 1;
      high_next  = ({1'b0, count_next} < half);
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         divisor   <= DEFAULT_DIVISOR;
         count     <= '0;
         clock_out <= 1'b0;
         tick      <= 1'b0;
      end else if (load || sync) begin
         if (load) divisor <= load_divisor;
         count     <= '0;
         clock_out <= 1'b0;
         tick      <= 1'b0;
      end else if (divisor == '0) begin
         count     <= '0;
         clock_out <= 1'b0;
         tick      <= 1'b0;
      end else if (enable) begin
         count     <= count_next;
         tick      <= wrap;
         clock_out <= high_next;
      end else begin
         tick      <= 1'b0;
      end
   end

`ifdef PRESCALER_PHASE_OUT_EN
   assign phase = count;
`endif

endmodule

// File: rtl/prescaler_multi.sv
// CHANNELS independent loadable clock dividers with shared sync and load port.
// Define PRESCALER_PHASE_OUT_EN to expose every channel's live count on `phase`.
module prescaler_multi
   import prescaler_pkg::*;
#(
   parameter int unsigned      CHANNELS        = 2,
   parameter int unsigned      WIDTH           = DIVISOR_WIDTH,
   parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = WIDTH'(DIVISOR_1HZ)
) (
   input  logic                                          clock_in,
   input  logic                                          reset,
   input  logic [CHANNELS-1:0]                           enable,
   input  logic                                          sync,
   input  logic                                          load_valid,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] load_channel,
   input  logic [WIDTH-1:0]                              load_divisor,
   output logic [CHANNELS-1:0]                           clock_out,
   output logic [CHANNELS-1:0]                           tick
`ifdef PRESCALER_PHASE_OUT_EN
   ,
   output logic [CHANNELS*WIDTH-1:0]                     phase
`endif
);

   // Out-of-range load_channel values match no channel and are dropped
   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic load_hit;
      assign load_hit = load_valid && (int'(load_channel) == c);

      prescaler_channel #(
         .WIDTH           (WIDTH),
         .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
      ) u_channel (
         .clock_in     (clock_in),
         .reset        (reset),
         .enable       (enable[c]),
         .sync         (sync),
         .load         (load_hit),
         .load_divisor (load_divisor),
         .clock_out    (clock_out[c]),
         .tick         (tick[c])
`ifdef PRESCALER_PHASE_OUT_EN
         ,
         .phase        (phase[c*WIDTH +: WIDTH])
`endif
      );
   end

endmodule

// File: tb/tb_prescaler_multi.sv
// Randomized and directed bench for prescaler_multi against a cycle-index reference model.
module tb_prescaler_multi;

   localparam int unsigned CH  = 3;
   localparam int unsigned W   = 16;
   localparam int unsigned DEF = 50;
   localparam int unsigned SW  = 2;

   logic          clock_in = 1'b0;
   logic          reset = 1'b1;
   logic [CH-1:0] enable = '0;
   logic          sync = 1'b0;
   logic          load_valid = 1'b0;
   logic [SW-1:0] load_channel = '0;
   logic [W-1:0]  load_divisor = '0;
   logic [CH-1:0] clock_out;
   logic [CH-1:0] tick;
`ifdef PRESCALER_PHASE_OUT_EN
   logic [CH*W-1:0] phase;
`endif

   prescaler_multi #(
      .CHANNELS        (CH),
      .WIDTH           (W),
      .DEFAULT_DIVISOR (W'(DEF))
   ) dut (
      .clock_in     (clock_in),
      .reset        (reset),
      .enable       (enable),
      .sync         (sync),
      .load_valid   (load_valid),
      .load_channel (load_channel),
      .load_divisor (load_divisor),
      .clock_out    (clock_out),
      .tick         (tick)
`ifdef PRESCALER_PHASE_OUT_EN
      ,
      .phase        (phase)
`endif
   );

   always #5 clock_in = ~clock_in;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: per channel, t = enabled edges since last restart; phase = t mod d
   longint unsigned m_div [CH];
   longint unsigned m_t   [CH];
   bit              m_co  [CH];
   bit              m_tk  [CH];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < CH; c++) begin
         if (reset) begin
            m_div[c] = DEF; m_t[c] = 0; m_co[c] = 0; m_tk[c] = 0;
         end else if ((load_valid && int'(load_channel) == c) || sync) begin
            if (load_valid && int'(load_channel) == c) m_div[c] = load_divisor;
            m_t[c] = 0; m_co[c] = 0; m_tk[c] = 0;
         end else if (m_div[c] == 0) begin
            m_t[c] = 0; m_co[c] = 0; m_tk[c] = 0;
         end else if (enable[c]) begin
            m_t[c]++;
            m_co[c] = (m_t[c] % m_div[c]) < ((m_div[c] + 1) / 2);
            m_tk[c] = (m_t[c] % m_div[c]) == 0;
         end else begin
            m_tk[c] = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clock_in);
      model_edge();
      #1;
      for (int c = 0; c < CH; c++) begin
         check($sformatf("clock_out[%0d]", c), 64'(clock_out[c]), 64'(m_co[c]));
         check($sformatf("tick[%0d]", c), 64'(tick[c]), 64'(m_tk[c]));
`ifdef PRESCALER_PHASE_OUT_EN
         check($sformatf("phase[%0d]", c), 64'(phase[c*W +: W]),
               (m_div[c] == 0) ? 64'd0 : 64'(m_t[c] % m_div[c]));
`endif
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic load(input int ch, input int d);
      load_valid = 1'b1; load_channel = SW'(ch); load_divisor = W'(d);
      step();
      load_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] pat_co;
      logic [7:0] pat_tk;
      int         cnt0, cnt1, last;
      bit         acc;

      reset = 1'b1;
      run(2);
      check("reset_clock_out", 64'(clock_out), 64'd0);
      check("reset_tick", 64'(tick), 64'd0);
      reset = 1'b0;

      // d=4 on ch0: waveform and period
      enable = 3'b001;
      load(0, 4);
      pat_co = '0; pat_tk = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         pat_co = {pat_co[8:0], clock_out[0]};
         pat_tk = {pat_tk[6:0], tick[0]};
      end
      check("d4_co_pattern", 64'(pat_co[7:0]), 64'b10011001);
      check("d4_tick_pattern", 64'(pat_tk), 64'b00010001);
      cnt0 = 0; last = 8;
      for (int i = 9; i <= 88; i++) begin
         step();
         if (tick[0]) begin
            cnt0++;
            check("d4_tick_interval", 64'(i - last), 64'd4);
            check("d4_rise_with_tick", 64'(clock_out[0]), 64'd1);
            last = i;
         end
      end
      check("d4_tick_count", 64'(cnt0), 64'd20);

      // d=5 on ch1: high 3, low 2
      enable = 3'b011;
      load(1, 5);
      pat_co = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         pat_co = {pat_co[8:0], clock_out[1]};
      end
      check("d5_co_pattern", 64'(pat_co), 64'b1100111001);

      // d=1 constant high, d=0 halted
      load(0, 1);
      acc = 1'b1;
      for (int i = 0; i < 10; i++) begin step(); acc &= clock_out[0] & tick[0]; end
      check("d1_const_high", 64'(acc), 64'd1);
      load(0, 0);
      acc = 1'b0;
      for (int i = 0; i < 50; i++) begin step(); acc |= clock_out[0] | tick[0]; end
      check("d0_halted", 64'(acc), 64'd0);

      // Sync at arbitrary offset with d=4 / d=6
      load(0, 4);
      load(1, 6);
      run($urandom_range(3, 20));
      sync = 1'b1; step(); sync = 1'b0;
      check("sync_edge_low", 64'(clock_out[1:0]), 64'd0);
      step();
      check("sync_rise_together", 64'(clock_out[1:0]), 64'b11);
`ifdef PRESCALER_PHASE_OUT_EN
      check("sync_phase0", 64'(phase[0 +: W]), 64'd1);
      check("sync_phase1", 64'(phase[W +: W]), 64'd1);
`endif

      // Enable drop at count 3 on d=8
      load(0, 8);
      run(3);
      enable[0] = 1'b0;
      run(10);
      enable[0] = 1'b1;
      pat_tk = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         pat_tk = {pat_tk[6:0], tick[0]};
`ifdef PRESCALER_PHASE_OUT_EN
         check("resume_phase", 64'(phase[0 +: W]), 64'((4 + i) % 8));
`endif
      end
      check("resume_tick_pattern", 64'(pat_tk[4:0]), 64'b00001);

      // Same-edge load ch0 d=3 and sync; ch1 stays at d=6
      load_valid = 1'b1; load_channel = 2'd0; load_divisor = 16'd3; sync = 1'b1;
      step();
      load_valid = 1'b0; sync = 1'b0;
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         cnt0 += int'(tick[0]);
         cnt1 += int'(tick[1]);
      end
      check("same_edge_ch0_ticks", 64'(cnt0), 64'd4);
      check("same_edge_ch1_ticks", 64'(cnt1), 64'd2);

      // Out-of-range channel is ignored
      load(3, 7);
      run(12);

      // Reset mid-period reverts divisor to default
      enable = 3'b111;
      load(2, 10);
      run(4);
      reset = 1'b1; step(); reset = 1'b0;
      check("midreset_clock_out", 64'(clock_out), 64'd0);
      check("midreset_tick", 64'(tick), 64'd0);
      cnt0 = 0;
      for (int i = 0; i < 20; i++) begin step(); cnt0 += int'(tick[2]); end
      check("midreset_no_tick", 64'(cnt0), 64'd0);
`ifdef PRESCALER_PHASE_OUT_EN
      check("midreset_phase_past10", 64'(phase[2*W +: W] > 10), 64'd1);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         enable       = CH'($urandom);
         load_valid   = ($urandom_range(0, 15) == 0);
         load_channel = SW'($urandom_range(0, 3));
         load_divisor = W'($urandom_range(0, 9));
         sync         = ($urandom_range(0, 31) == 0);
         reset        = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0; load_valid = 1'b0; sync = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
